// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, 3x3 window with centre coordinates out
interface sobel_window_gen_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 12
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  logic [PIX_W-1:0]             pix_in;
  logic                         pix_valid;
  logic                         sof;
  logic [2:0][2:0][PIX_W-1:0]   data_matrix;
  logic                         win_valid;
  logic [XW-1:0]                center_x;
  logic [YW-1:0]                center_y;
  logic                         frame_done;
  modport master (
    output pix_in, pix_valid, sof,
    input  data_matrix, win_valid, center_x, center_y, frame_done
  );
  modport slave (
    input  pix_in, pix_valid, sof,
    output data_matrix, win_valid, center_x, center_y, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: two line buffers feeding a registered 3x3 window for interior pixels
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 12
) (
  input logic clk,
  input logic rst,
  sobel_window_gen_if.slave bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];
  logic [XW-1:0] col, x;
  logic [YW-1:0] row, y;
  logic acc, last_x, last_y, emit;
  // sof forces the accepted pixel to (0,0) regardless of where the counters are
  always_comb begin
    acc    = bus.pix_valid;
    x      = bus.sof ? '0 : col;
    y      = bus.sof ? '0 : row;
    last_x = x == XW'(IMG_WIDTH - 1);
    last_y = y == YW'(IMG_HEIGHT - 1);
    emit   = acc && x >= XW'(2) && y >= YW'(2);
  end
  // line buffers age one row per accepted pixel; contents need no reset
  always_ff @(posedge clk) begin
    if (acc && !rst) begin
      lb2[x] <= lb1[x];
      lb1[x] <= bus.pix_in;
    end
  end
  // position counters, window shift register and output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      col             <= '0;
      row             <= '0;
      bus.data_matrix <= '0;
      bus.win_valid   <= 1'b0;
      bus.center_x    <= '0;
      bus.center_y    <= '0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.win_valid  <= emit;
      bus.frame_done <= acc && last_x && last_y;
      if (acc) begin
        col <= last_x ? '0 : x + 1'b1;
        row <= last_x ? (last_y ? '0 : y + 1'b1) : y;
        for (int r = 0; r < 3; r++) begin
          bus.data_matrix[r][0] <= bus.data_matrix[r][1];
          bus.data_matrix[r][1] <= bus.data_matrix[r][2];
        end
        bus.data_matrix[0][2] <= lb2[x];
        bus.data_matrix[1][2] <= lb1[x];
        bus.data_matrix[2][2] <= bus.pix_in;
      end
      if (emit) begin
        bus.center_x <= x - 1'b1;
        bus.center_y <= y - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: randomized directed scenarios checked against an image-array model
module tb_sobel_window_gen;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  int nwin, nfd, nacc;
  int fd_q[$];
  int mx, my, ecx, ecy;
  logic ev, efd;
  int img [H][W];
  int ew [3][3];

  sobel_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(12)) ifc ();
  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [11:0] p, input logic r);
    rst = r;
    ifc.pix_valid = v;
    ifc.sof = s;
    ifc.pix_in = p;
    @(posedge clk);
    ev = 1'b0;
    efd = 1'b0;
    if (r) begin
      mx = 0;
      my = 0;
    end else if (v) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      nacc++;
      img[my][mx] = int'(p);
      ev = mx >= 2 && my >= 2;
      if (ev) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            ew[rr][cc] = img[my-2+rr][mx-2+cc];
        ecx = mx - 1;
        ecy = my - 1;
      end
      efd = mx == W-1 && my == H-1;
      mx = mx + 1;
      if (mx == W) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end
    end
    #1;
    chk("win_valid", 32'(ifc.win_valid), 32'(ev));
    chk("frame_done", 32'(ifc.frame_done), 32'(efd));
    if (ifc.win_valid === 1'b1) nwin++;
    if (ifc.frame_done === 1'b1) begin
      nfd++;
      fd_q.push_back(nacc);
    end
    if (ev) begin
      chk("center_x", 32'(ifc.center_x), ecx);
      chk("center_y", 32'(ifc.center_y), ecy);
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          chk($sformatf("data[%0d][%0d]", rr, cc), 32'(ifc.data_matrix[rr][cc]), ew[rr][cc]);
    end
  endtask

  task automatic send_px(input int base, input int lo, input int hi, input bit sofi, input int stall);
    for (int i = lo; i < hi; i++) begin
      while (int'($urandom_range(99)) < stall)
        step(1'b0, 1'($urandom_range(1)), 12'($urandom), 1'b0);
      step(1'b1, sofi && i == lo, 12'(base + 16*(i/W) + i%W), 1'b0);
    end
  endtask

  task automatic chk_window(input string tag, input int base);
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        chk(tag, 32'(ifc.data_matrix[rr][cc]), base + 16*rr + cc);
  endtask

  initial begin
    ifc.pix_valid = 1'b0;
    ifc.sof = 1'b0;
    ifc.pix_in = '0;
    nacc = 0;
    mx = 0;
    my = 0;
    // reset with random traffic on the inputs
    repeat (2) step(1'($urandom_range(1)), 1'($urandom_range(1)), 12'($urandom), 1'b1);
    chk("rst_data", 32'(ifc.data_matrix), 32'(0));
    chk("rst_cx", 32'(ifc.center_x), 32'(0));
    chk("rst_cy", 32'(ifc.center_y), 32'(0));
    // continuous frame
    nwin = 0;
    nfd = 0;
    send_px(0, 0, 13, 1'b1, 0);
    chk("first_cx", 32'(ifc.center_x), 32'(1));
    chk("first_cy", 32'(ifc.center_y), 32'(1));
    chk_window("first_win", 0);
    send_px(0, 13, 20, 1'b0, 0);
    chk("last_cx", 32'(ifc.center_x), 32'(3));
    chk("last_cy", 32'(ifc.center_y), 32'(2));
    chk("last_22", 32'(ifc.data_matrix[2][2]), 32'h034);
    step(1'b0, 1'b0, 12'h0, 1'b0);
    chk("cont_windows", nwin, 6);
    chk("cont_frame_done", nfd, 1);
    // stalled frame
    nwin = 0;
    send_px(0, 0, 20, 1'b1, 40);
    chk("stall_windows", nwin, 6);
    // mid-frame sof
    nwin = 0;
    send_px(0, 0, 12, 1'b1, 0);
    send_px(16'h100, 0, 13, 1'b1, 0);
    chk("sof_first_11", 32'(ifc.data_matrix[1][1]), 32'h111);
    chk_window("sof_first_win", 16'h100);
    send_px(16'h100, 13, 20, 1'b0, 0);
    chk("sof_windows", nwin, 6);
    // reset during row 2
    send_px(0, 0, 12, 1'b1, 0);
    step(1'b1, 1'b0, 12'($urandom), 1'b1);
    chk("midrst_data", 32'(ifc.data_matrix), 32'(0));
    nwin = 0;
    send_px(0, 0, 20, 1'b0, 0);
    chk("midrst_windows", nwin, 6);
    // back-to-back frames, sof only on the first
    nwin = 0;
    nfd = 0;
    fd_q.delete();
    send_px(0, 0, 20, 1'b1, 0);
    send_px(0, 0, 20, 1'b0, 0);
    step(1'b0, 1'b0, 12'h0, 1'b0);
    chk("b2b_windows", nwin, 12);
    chk("b2b_frame_done", nfd, 2);
    if (fd_q.size() == 2) chk("b2b_spacing", fd_q[1] - fd_q[0], 20);
    else chk("b2b_fd_count", fd_q.size(), 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
